// File: rtl/cpu_pkg.sv
// Shared LSU definitions: FSM state encoding, funct3 constants, error causes
// and the access-size helpers used by the load/store sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_RD,
    LSU_DONE,
    LSU_ERR
  } lsu_state_e;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  function automatic logic [7:0] size_be(input logic [1:0] size);
    logic [7:0] be;
    case (size)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0F;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load return path: picks the addressed lane out of the read doubleword and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import cpu_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  logic [63:0] lane;

  always_comb begin
    lane   = rdata_i >> {off_i, 3'b000};
    data_o = lane;
    case (funct3_i)
      F3_B:    data_o = {{56{lane[7]}},  lane[7:0]};
      F3_H:    data_o = {{48{lane[15]}}, lane[15:0]};
      F3_W:    data_o = {{32{lane[31]}}, lane[31:0]};
      F3_D:    data_o = lane;
      F3_BU:   data_o = {56'd0, lane[7:0]};
      F3_HU:   data_o = {48'd0, lane[15:0]};
      F3_LWU:  data_o = {32'd0, lane[31:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between decode and the data-memory bus.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsu_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        err,
  output logic [1:0]  err_cause
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        f3_q, f3_d;
  logic [2:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_be_q, mem_be_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [63:0]       wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [1:0]        err_cause_q, err_cause_d;

  logic              accept;
  logic              illegal;
  logic              misalign_trap;
  logic              timed_out;
  logic [1:0]        size;
  logic [2:0]        aligned_off;
  logic [63:0]       load_data;

  assign accept      = req_valid & (req_is_load | req_is_store);
  assign size        = req_funct3[1:0];
  assign illegal     = req_is_load ? (req_funct3 == 3'b111) : req_funct3[2];
  assign aligned_off = req_addr[2:0] & ~size_mask(size);
  assign timed_out   = (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = |(req_addr[2:0] & size_mask(size));
`else
  assign misalign_trap = 1'b0;
`endif

  lsu_load_align u_align (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      is_load_q   <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
      err_cause_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_load_q   <= is_load_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    is_load_d   = is_load_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    err_cause_d = err_cause_q;
    stall       = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          is_load_d = req_is_load;
          f3_d      = req_funct3;
          rd_d      = req_rd;
          if (illegal) begin
            state_d     = LSU_ERR;
            err_d       = 1'b1;
            err_cause_d = ERR_ILLEGAL;
          end else if (misalign_trap) begin
            state_d     = LSU_ERR;
            err_d       = 1'b1;
            err_cause_d = ERR_MISALIGN;
          end else begin
            // Low bits are force-aligned here so the bus and load lanes agree.
            state_d     = LSU_REQ;
            off_d       = aligned_off;
            mem_valid_d = 1'b1;
            mem_we_d    = ~req_is_load;
            mem_addr_d  = {req_addr[63:3], 3'b000};
            mem_be_d    = size_be(size) << aligned_off;
            mem_wdata_d = req_wdata << {aligned_off, 3'b000};
          end
        end
      end

      LSU_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (timed_out) begin
          state_d     = LSU_ERR;
          cnt_d       = '0;
          mem_valid_d = 1'b0;
          err_d       = 1'b1;
          err_cause_d = ERR_TIMEOUT;
        end else if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (is_load_q) begin
            state_d = LSU_WAIT_RD;
          end else begin
            state_d = LSU_DONE;
            cnt_d   = '0;
          end
        end
      end

      LSU_WAIT_RD: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (timed_out) begin
          state_d     = LSU_ERR;
          cnt_d       = '0;
          err_d       = 1'b1;
          err_cause_d = ERR_TIMEOUT;
        end else if (mem_rvalid) begin
          state_d    = LSU_DONE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
        end
      end

      LSU_DONE: begin
        state_d = LSU_IDLE;
      end

      LSU_ERR: begin
        state_d     = LSU_IDLE;
        err_cause_d = ERR_NONE;
      end

      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;
  assign err_cause = err_cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset-mid-load sequence and
// randomized ops checked against an arithmetic reference model.
module tb_lsu_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, mem_valid, mem_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic        mem_rvalid;
  logic        wb_valid, err;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  err_cause;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err(err), .err_cause(err_cause)
  );

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [63:0] addr, wdata, rdata;
    logic [4:0]  rd;
    int          rdy_dly, rv_dly;
    bit          noise;
  } op_t;

  typedef struct {
    bit          bus, we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    bit          wb;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic [1:0]  cause;
    int          stall, mv;
  } exp_t;

  typedef struct {
    bit          hung, we, unstable;
    int          stalls, mv, wb_cnt, err_cnt;
    logic [63:0] addr, wdata, wb_data;
    logic [7:0]  be;
    logic [4:0]  wb_rd;
    logic [1:0]  cause;
  } obs_t;

  typedef struct { op_t op; exp_t e; } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic op_t mk_op(input bit ld, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd, input logic [63:0] rdat,
                                input logic [4:0] rd, input int d, input int r);
    op_t o;
    o.is_load = ld; o.f3 = f3; o.addr = a; o.wdata = wd; o.rdata = rdat;
    o.rd = rd; o.rdy_dly = d; o.rv_dly = r; o.noise = 1'b0;
    return o;
  endfunction

  function automatic exp_t mk_exp(input bit bus, input bit we, input logic [63:0] a,
                                  input logic [7:0] be, input logic [63:0] wd, input bit wb,
                                  input logic [63:0] wbd, input logic [4:0] wbr,
                                  input logic [1:0] cause, input int st, input int mv);
    exp_t e;
    e.bus = bus; e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.wb = wb;
    e.wb_data = wbd; e.wb_rd = wbr; e.cause = cause; e.stall = st; e.mv = mv;
    return e;
  endfunction

  // Reference model: outcome of one op from size/alignment arithmetic and bus delays.
  function automatic exp_t model(input op_t op);
    exp_t e;
    int unsigned sz;
    longint unsigned a, eff, off, raw, lim;
    int used;
    e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    sz = 1 << op.f3[1:0];
    if (op.is_load ? (op.f3 == 3'd7) : (op.f3 >= 3'd4)) begin
      e.cause = 2'd3;
      return e;
    end
    a = op.addr;
`ifdef LSU_MISALIGN_TRAP_EN
    if (a % sz != 0) begin
      e.cause = 2'd2;
      return e;
    end
`endif
    eff     = a - (a % sz);
    off     = eff % 8;
    e.bus   = 1;
    e.we    = !op.is_load;
    e.addr  = eff - off;
    e.be    = 8'(((1 << sz) - 1) << off);
    e.wdata = op.wdata << (8 * off);
    used    = op.is_load ? (op.rdy_dly + op.rv_dly) : op.rdy_dly;
    if (used >= TO - 1) begin
      e.cause = 2'd1;
      e.stall = 1 + TO;
      e.mv    = (op.rdy_dly + 1 < TO) ? op.rdy_dly + 1 : TO;
      return e;
    end
    e.mv    = op.rdy_dly + 1;
    e.stall = 1 + op.rdy_dly + 1 + (op.is_load ? op.rv_dly : 0);
    if (op.is_load) begin
      raw = op.rdata >> (8 * off);
      if (sz < 8) begin
        lim = 64'd1 << (8 * sz);
        raw = raw % lim;
        if (op.f3 < 3'd4 && raw >= lim / 2) raw = raw - lim;
      end
      e.wb      = 1;
      e.wb_data = raw;
      e.wb_rd   = op.rd;
    end
    return e;
  endfunction

  // Drives one op from IDLE with a simple bus responder; returns what was seen.
  task automatic run_op(input op_t op, output obs_t o);
    int vcnt, since, phase;
    bit hs_seen, hs;
    o = '{default: 0};
    req_valid = 1'b1; req_is_load = op.is_load; req_is_store = !op.is_load;
    req_funct3 = op.f3; req_addr = op.addr; req_wdata = op.wdata; req_rd = op.rd;
    vcnt = 0; since = 0; phase = 0; hs_seen = 0;
    o.hung = 1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      mem_ready  = mem_valid && (vcnt >= op.rdy_dly);
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (hs_seen && (since + 1 == op.rv_dly)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = op.rdata;
      end else if (op.noise && !hs_seen) begin
        mem_rvalid = 1'($urandom_range(0, 1));
      end
      #1;
      if (stall) o.stalls++;
      if (mem_valid) begin
        if (o.mv == 0) begin
          o.we = mem_we; o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata;
        end else if (o.we !== mem_we || o.addr !== mem_addr || o.be !== mem_be || o.wdata !== mem_wdata) begin
          o.unstable = 1;
        end
        o.mv++;
      end
      if (wb_valid) begin o.wb_cnt++; o.wb_data = wb_data; o.wb_rd = wb_rd; end
      if (err) begin o.err_cnt++; o.cause = err_cause; end
      hs = mem_valid && mem_ready;
      if (phase == 1) begin o.hung = 0; break; end
      if (!stall) begin phase = 1; req_valid = 1'b0; end
      if (hs) begin hs_seen = 1; since = 0; end
      else if (hs_seen) since++;
      if (mem_valid) vcnt++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_obs(input string tag, input exp_t e, input obs_t o);
    chk({tag, "/hung"}, 64'(o.hung), 64'd0);
    chk({tag, "/err_count"}, 64'(o.err_cnt), 64'(e.cause != 2'd0));
    chk({tag, "/err_cause"}, 64'(o.cause), 64'(e.cause));
    chk({tag, "/wb_count"}, 64'(o.wb_cnt), 64'(e.wb));
    if (e.wb) begin
      chk({tag, "/wb_data"}, o.wb_data, e.wb_data);
      chk({tag, "/wb_rd"}, 64'(o.wb_rd), 64'(e.wb_rd));
    end
    chk({tag, "/stall_cycles"}, 64'(o.stalls), 64'(e.stall));
    chk({tag, "/mem_valid_cycles"}, 64'(o.mv), 64'(e.mv));
    if (e.bus) begin
      chk({tag, "/mem_we"}, 64'(o.we), 64'(e.we));
      chk({tag, "/mem_addr"}, o.addr, e.addr);
      chk({tag, "/mem_be"}, 64'(o.be), 64'(e.be));
      chk({tag, "/mem_wdata"}, o.wdata, e.wdata);
      chk({tag, "/held_stable"}, 64'(o.unstable), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    obs_t o;
    op_t  op;
    int   wbc;

    tbl.push_back('{mk_op(0, 3'd2, 64'h1004, 64'hDEADBEEF, 0, 0, 0, 1),
                    mk_exp(1, 1, 64'h1000, 8'hF0, 64'hDEADBEEF_00000000, 0, 0, 0, 2'd0, 2, 1)});
    tbl.push_back('{mk_op(1, 3'd0, 64'h2003, 0, 64'h00000000_80000000, 5, 0, 1),
                    mk_exp(1, 0, 64'h2000, 8'h08, 0, 1, 64'hFFFFFFFF_FFFFFF80, 5, 2'd0, 3, 1)});
    tbl.push_back('{mk_op(1, 3'd4, 64'h2003, 0, 64'h00000000_80000000, 6, 0, 1),
                    mk_exp(1, 0, 64'h2000, 8'h08, 0, 1, 64'h80, 6, 2'd0, 3, 1)});
    tbl.push_back('{mk_op(1, 3'd3, 64'h4008, 0, 64'h01234567_89ABCDEF, 10, 5, 1),
                    mk_exp(1, 0, 64'h4008, 8'hFF, 0, 1, 64'h01234567_89ABCDEF, 10, 2'd0, 8, 6)});
    tbl.push_back('{mk_op(1, 3'd2, 64'h5000, 0, 0, 3, 0, 100),
                    mk_exp(1, 0, 64'h5000, 8'h0F, 0, 0, 0, 0, 2'd1, 17, 1)});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{mk_op(0, 3'd1, 64'h3001, 64'h1234, 0, 0, 0, 1),
                    mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 1, 0)});
`else
    tbl.push_back('{mk_op(0, 3'd1, 64'h3001, 64'h1234, 0, 0, 0, 1),
                    mk_exp(1, 1, 64'h3000, 8'h03, 64'h1234, 0, 0, 0, 2'd0, 2, 1)});
`endif
    tbl.push_back('{mk_op(0, 3'd4, 64'h0100, 64'h55, 0, 0, 0, 1),
                    mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 1, 0)});
    tbl.push_back('{mk_op(1, 3'd7, 64'h0100, 0, 0, 1, 0, 1),
                    mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 1, 0)});
    tbl.push_back('{mk_op(1, 3'd6, 64'h6004, 0, 64'h89ABCDEF_00000000, 1, 0, 1),
                    mk_exp(1, 0, 64'h6000, 8'hF0, 0, 1, 64'h00000000_89ABCDEF, 1, 2'd0, 3, 1)});
    tbl.push_back('{mk_op(1, 3'd2, 64'h6004, 0, 64'h89ABCDEF_00000000, 1, 0, 1),
                    mk_exp(1, 0, 64'h6000, 8'hF0, 0, 1, 64'hFFFFFFFF_89ABCDEF, 1, 2'd0, 3, 1)});
    tbl.push_back('{mk_op(1, 3'd1, 64'h7006, 0, 64'hFEDC0000_00000000, 2, 0, 2),
                    mk_exp(1, 0, 64'h7000, 8'hC0, 0, 1, 64'hFFFFFFFF_FFFFFEDC, 2, 2'd0, 4, 1)});
    tbl.push_back('{mk_op(1, 3'd5, 64'h7006, 0, 64'hFEDC0000_00000000, 2, 0, 1),
                    mk_exp(1, 0, 64'h7000, 8'hC0, 0, 1, 64'h00000000_0000FEDC, 2, 2'd0, 3, 1)});
    tbl.push_back('{mk_op(0, 3'd0, 64'h8007, 64'hAB, 0, 0, 0, 1),
                    mk_exp(1, 1, 64'h8000, 8'h80, 64'hAB000000_00000000, 0, 0, 0, 2'd0, 2, 1)});
    tbl.push_back('{mk_op(0, 3'd3, 64'h9000, 64'h11223344_55667788, 0, 0, 2, 1),
                    mk_exp(1, 1, 64'h9000, 8'hFF, 64'h11223344_55667788, 0, 0, 0, 2'd0, 4, 3)});
    tbl.push_back('{mk_op(1, 3'd3, 64'hB000, 0, 64'hCAFE, 4, 13, 1),
                    mk_exp(1, 0, 64'hB000, 8'hFF, 0, 1, 64'hCAFE, 4, 2'd0, 16, 14)});
    tbl.push_back('{mk_op(1, 3'd3, 64'hB000, 0, 64'hCAFE, 4, 14, 1),
                    mk_exp(1, 0, 64'hB000, 8'hFF, 0, 0, 0, 0, 2'd1, 17, 15)});

    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/mem_valid", 64'(mem_valid), 64'd0);
    chk("reset/mem_we", 64'(mem_we), 64'd0);
    chk("reset/mem_addr", mem_addr, 64'd0);
    chk("reset/mem_be", 64'(mem_be), 64'd0);
    chk("reset/mem_wdata", mem_wdata, 64'd0);
    chk("reset/wb", {wb_valid, wb_rd, wb_data[57:0]}, 64'd0);
    chk("reset/err", {err, err_cause}, 64'd0);
    chk("reset/stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].op, o);
      check_obs($sformatf("vec%0d", i), tbl[i].e, o);
    end

    // Reset while a load waits for read data, with rvalid arriving at and after the reset edge.
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2;
    req_addr = 64'hA000; req_wdata = '0; req_rd = 5'd9; mem_ready = 1'b1; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid/req_mem_valid", 64'(mem_valid), 64'd1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("rst_mid/wait_stall", 64'(stall), 64'd1);
    rst = 1'b1; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h12345678_9ABCDEF0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid/mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mid/mem_addr", mem_addr, 64'd0);
    chk("rst_mid/mem_be", 64'(mem_be), 64'd0);
    chk("rst_mid/wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_mid/wb_data", wb_data, 64'd0);
    chk("rst_mid/stall", 64'(stall), 64'd0);
    wbc = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_valid || err || mem_valid) wbc++;
    end
    mem_rvalid = 1'b0;
    chk("rst_mid/late_rvalid_ignored", 64'(wbc), 64'd0);
    op = mk_op(1, 3'd2, 64'hA004, 0, 64'h7000_0001_0000_0000, 9, 0, 1);
    run_op(op, o);
    check_obs("rst_mid/next_load", model(op), o);

    for (int i = 0; i < 150; i++) begin
      op.is_load = 1'($urandom_range(0, 1));
      op.f3      = 3'($urandom_range(0, 7));
      op.addr    = {$urandom, $urandom};
      op.wdata   = {$urandom, $urandom};
      op.rdata   = {$urandom, $urandom};
      op.rd      = 5'($urandom_range(0, 31));
      op.rdy_dly = $urandom_range(0, 3);
      op.rv_dly  = ($urandom_range(0, 15) == 0) ? 100 : $urandom_range(1, 3);
      op.noise   = 1'b1;
      run_op(op, o);
      check_obs($sformatf("rand%0d", i), model(op), o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
